mux_4to1: RTL and testbench
===========================

Name: mux_4to1

Overview:
- Registered 4-to-1 selector.
- Picks one of four equal-width lanes packed into a single input bus, using a 2-bit select.
- Provides a combinational result and a one-cycle registered result, qualified by a valid strobe.
- Generic leaf cell used wherever a small lane select is needed in datapath or control logic.

Parameters:
- WIDTH, 1, bit width of each lane and of both outputs; legal range 1..64.
- REG_OUT, 1, 1 = out/out_valid are registered; 0 = out/out_valid equal out_comb/in_valid combinationally. Reset and enable logic is then unused.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in  input  4*WIDTH  packed lanes: lane k occupies in[k*WIDTH +: WIDTH], k = 0..3
- sel  input  2  lane select, binary encoded
- in_valid  input  1  qualifies in/sel for capture
- out_comb  output  WIDTH  combinational selected lane
- out  output  WIDTH  selected lane (registered when REG_OUT=1)
- out_valid  output  1  out holds a freshly captured selection

Behaviour:
- Combinational path:
  - out_comb = lane[sel] at all times, independent of clk, rst and in_valid.
  - sel=0 selects bits WIDTH-1..0; sel=3 selects the top lane.
  - All four sel codes are legal; no default or fallback lane exists.
  - With WIDTH=1, in=4'b1000 and sel=3 gives out_comb=1.
  - If sel contains X/Z, out_comb is X. No masking is required.
- Registered path (REG_OUT=1):
  - On a clk rising edge with rst=1: out <= 0 and out_valid <= 0, regardless of in_valid.
  - Else, with in_valid=1: out <= lane[sel] and out_valid <= 1.
  - Else, with in_valid=0: out holds its previous value and out_valid <= 0.
  - Latency is exactly one cycle from a sampled in_valid to out/out_valid.
  - Throughput is one selection per cycle. Back-to-back valids give a continuous out_valid with a new value every cycle.
  - Reset asserted mid-stream: the next edge clears both outputs, and any in_valid in that cycle is dropped. The first capture after reset is the first edge with rst=0 and in_valid=1.
- Reset values: out=0, out_valid=0. out_comb has no reset value because it is purely combinational.
- No backpressure and no ready signal; the consumer must accept out when out_valid=1.
- No internal state other than the WIDTH+1 output flops.

Decomposition:
- Shared package mux_pkg:
  - constant N_LANES=4
  - constant SEL_W=2
  - typedef sel_t (logic [SEL_W-1:0])
- One natural sub-module, mux_4to1_comb:
  - pure lane select (in, sel -> out_comb).
  - instantiated once by mux_4to1, which adds the output register, valid flop and REG_OUT generate.

Test Plan:
- WIDTH=1, REG_OUT=1, rst held 2 cycles -> out=0, out_valid=0 during and after reset until first in_valid.
- WIDTH=1, in_valid=1, apply in=8/sel=3, in=4/sel=2, in=2/sel=1, in=1/sel=0 on consecutive cycles:
  - out_comb=1 immediately for each pair.
  - out=1 and out_valid=1 on each following cycle.
- WIDTH=1, off-select cases in=8/sel=0, in=1/sel=3, in=4/sel=1 -> out_comb=0; registered out=0 one cycle later.
- WIDTH=8, in=32'hDDCCBBAA, sweep sel 0..3 with in_valid=1 -> out = AA, BB, CC, DD on successive cycles, out_valid continuously 1.
- Hold test: capture in=4/sel=2 (out=1), then in_valid=0 with in=0 -> out stays 1, out_valid=0; out_comb follows the new inputs (0).
- Reset mid-stream: in_valid=1 and rst=1 on the same edge -> out=0, out_valid=0 on that edge. Next edge with rst=0 captures normally.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and types for the 4-to-1 lane selector.
package mux_pkg;
  localparam int unsigned N_LANES = 4;
  localparam int unsigned SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux_4to1_comb.sv
// Pure combinational lane select: lane k lives at in[k*WIDTH +: WIDTH].
module mux_4to1_comb
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [N_LANES*WIDTH-1:0] in,
  input  sel_t                     sel,
  output logic [WIDTH-1:0]         out_comb
);

  // An X/Z select yields X through the indexed part-select; no masking wanted.
  always_comb begin
    out_comb = in[32'(sel)*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/mux_4to1.sv
// Registered 4-to-1 selector with a valid strobe; REG_OUT=0 bypasses the flops.
module mux_4to1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_LANES*WIDTH-1:0] in,
  input  sel_t                     sel,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_comb,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid
);

  logic [WIDTH-1:0] w_lane;

  mux_4to1_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .in      (in),
    .sel     (sel),
    .out_comb(w_lane)
  );

  assign out_comb = w_lane;

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] r_out;
      logic             r_out_valid;

      // Data holds when idle; valid is a one-cycle strobe per capture.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_out       <= '0;
          r_out_valid <= 1'b0;
        end else if (in_valid) begin
          r_out       <= w_lane;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end

      assign out       = r_out;
      assign out_valid = r_out_valid;
    end else begin : g_bypass
      logic w_unused;
      assign w_unused  = clk ^ rst;
      assign out       = w_lane;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_mux_4to1.sv
// Table-driven scoreboard bench for mux_4to1 at WIDTH=1 and WIDTH=8.
module tb_mux_4to1;

  typedef struct {
    int          w;
    logic [31:0] din;
    logic [1:0]  s;
    logic        v;
    logic        r;
    logic [7:0]  ec;
  } vec_t;

  typedef struct {
    int         w;
    logic [7:0] out;
    logic       vld;
  } exp_t;

  logic        clk = 1'b0;
  logic [3:0]  in1;
  logic [1:0]  sel1;
  logic        v1, rst1;
  logic [31:0] in8;
  logic [1:0]  sel8;
  logic        v8, rst8;

  logic       oc1, o1, ov1;
  logic [7:0] oc8, o8;
  logic       ov8;
  logic [7:0] ocb, ob;
  logic       ovb;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       sb[$];
  logic [7:0] m_out1, m_out8;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst1), .in(in1), .sel(sel1), .in_valid(v1),
    .out_comb(oc1), .out(o1), .out_valid(ov1)
  );

  mux_4to1 #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst(rst8), .in(in8), .sel(sel8), .in_valid(v8),
    .out_comb(oc8), .out(o8), .out_valid(ov8)
  );

  mux_4to1 #(.WIDTH(8), .REG_OUT(1'b0)) u_w8c (
    .clk(clk), .rst(rst8), .in(in8), .sel(sel8), .in_valid(v8),
    .out_comb(ocb), .out(ob), .out_valid(ovb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector, check combinational outputs, then score the registered result.
  task automatic apply(input vec_t t);
    exp_t e, g;
    if (t.w == 1) begin
      in1 = t.din[3:0]; sel1 = t.s; v1 = t.v; rst1 = t.r;
    end else begin
      in8 = t.din; sel8 = t.s; v8 = t.v; rst8 = t.r;
      v1 = 1'b0; rst1 = 1'b0;
    end
    #1;
    if (t.w == 1) begin
      check("w1_out_comb", 32'(oc1), 32'(t.ec[0]));
    end else begin
      check("w8_out_comb", 32'(oc8), 32'(t.ec));
      check("w8_bypass_out", 32'(ob), 32'(t.ec));
      check("w8_bypass_valid", 32'(ovb), 32'(t.v));
    end
    e.w = t.w;
    if (t.w == 1) begin
      if (t.r)      m_out1 = 8'h00;
      else if (t.v) m_out1 = {7'b0, t.ec[0]};
      e.out = m_out1;
    end else begin
      if (t.r)      m_out8 = 8'h00;
      else if (t.v) m_out8 = t.ec;
      e.out = m_out8;
    end
    e.vld = t.v & ~t.r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      g = sb.pop_front();
      if (g.w == 1) begin
        check("w1_out", 32'(o1), 32'(g.out));
        check("w1_out_valid", 32'(ov1), 32'(g.vld));
      end else begin
        check("w8_out", 32'(o8), 32'(g.out));
        check("w8_out_valid", 32'(ov8), 32'(g.vld));
      end
    end
  endtask

  function automatic vec_t mk(int w, logic [31:0] din, logic [1:0] s, logic v, logic r, logic [7:0] ec);
    vec_t t;
    t.w = w; t.din = din; t.s = s; t.v = v; t.r = r; t.ec = ec;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    in1 = 4'h0; sel1 = 2'd0; v1 = 1'b0; rst1 = 1'b1;
    in8 = 32'h0; sel8 = 2'd0; v8 = 1'b0; rst8 = 1'b1;
    m_out1 = 8'h00; m_out8 = 8'h00;

    // WIDTH=1: reset, idle, on-select, off-select, hold, reset mid-stream
    tbl.push_back(mk(1, 32'h0, 2'd0, 1'b0, 1'b1, 8'h0));
    tbl.push_back(mk(1, 32'h8, 2'd3, 1'b1, 1'b1, 8'h1));
    tbl.push_back(mk(1, 32'h0, 2'd0, 1'b0, 1'b0, 8'h0));
    tbl.push_back(mk(1, 32'h8, 2'd3, 1'b1, 1'b0, 8'h1));
    tbl.push_back(mk(1, 32'h4, 2'd2, 1'b1, 1'b0, 8'h1));
    tbl.push_back(mk(1, 32'h2, 2'd1, 1'b1, 1'b0, 8'h1));
    tbl.push_back(mk(1, 32'h1, 2'd0, 1'b1, 1'b0, 8'h1));
    tbl.push_back(mk(1, 32'h8, 2'd0, 1'b1, 1'b0, 8'h0));
    tbl.push_back(mk(1, 32'h1, 2'd3, 1'b1, 1'b0, 8'h0));
    tbl.push_back(mk(1, 32'h4, 2'd1, 1'b1, 1'b0, 8'h0));
    tbl.push_back(mk(1, 32'h4, 2'd2, 1'b1, 1'b0, 8'h1));
    tbl.push_back(mk(1, 32'h0, 2'd0, 1'b0, 1'b0, 8'h0));
    tbl.push_back(mk(1, 32'h0, 2'd2, 1'b0, 1'b0, 8'h0));
    tbl.push_back(mk(1, 32'h8, 2'd3, 1'b1, 1'b1, 8'h1));
    tbl.push_back(mk(1, 32'h8, 2'd3, 1'b1, 1'b0, 8'h1));
    // WIDTH=8: reset then back-to-back lane sweep
    tbl.push_back(mk(8, 32'hDDCCBBAA, 2'd0, 1'b0, 1'b1, 8'hAA));
    tbl.push_back(mk(8, 32'hDDCCBBAA, 2'd0, 1'b1, 1'b0, 8'hAA));
    tbl.push_back(mk(8, 32'hDDCCBBAA, 2'd1, 1'b1, 1'b0, 8'hBB));
    tbl.push_back(mk(8, 32'hDDCCBBAA, 2'd2, 1'b1, 1'b0, 8'hCC));
    tbl.push_back(mk(8, 32'hDDCCBBAA, 2'd3, 1'b1, 1'b0, 8'hDD));

    @(posedge clk);
    #1;
    check("w1_reset_out", 32'(o1), 32'h0);
    check("w1_reset_valid", 32'(ov1), 32'h0);

    foreach (tbl[i]) apply(tbl[i]);

    // WIDTH=8 hold: capture CC, then idle with zeroed inputs
    apply(mk(8, 32'hDDCCBBAA, 2'd2, 1'b1, 1'b0, 8'hCC));
    apply(mk(8, 32'h00000000, 2'd2, 1'b0, 1'b0, 8'h00));
    apply(mk(8, 32'h00000000, 2'd0, 1'b0, 1'b0, 8'h00));
    // WIDTH=8 reset mid-stream drops the valid, next edge captures
    apply(mk(8, 32'hDDCCBBAA, 2'd1, 1'b1, 1'b0, 8'hBB));
    apply(mk(8, 32'hDDCCBBAA, 2'd3, 1'b1, 1'b1, 8'hDD));
    apply(mk(8, 32'hDDCCBBAA, 2'd1, 1'b1, 1'b0, 8'hBB));
    apply(mk(8, 32'h12345678, 2'd3, 1'b1, 1'b0, 8'h12));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
